// File: rtl/dtree_seq_eval.sv
// Sequential decision-tree evaluator: walks a programmable node table one node
// per cycle with a single shared comparator, then holds the class until taken.
module dtree_seq_eval #(
  parameter int NFEAT = 8,
  parameter int FW    = 8,
  parameter int NODES = 16,
  parameter int CW    = 2,
  localparam int AW   = $clog2(NODES),
  localparam int NW   = 1 + 3 + FW + 2*AW
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [AW-1:0]       cfg_addr,
  input  logic [NW-1:0]       cfg_wdata,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NFEAT*FW-1:0] in_feat,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CW-1:0]       out_class,
  output logic                out_err
);

  typedef struct packed {
    logic          leaf;
    logic [2:0]    fidx;
    logic [FW-1:0] thr;
    logic [AW-1:0] left;
    logic [AW-1:0] right;
  } node_t;

  typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

  state_t                   state;
  node_t                    tbl [NODES];
  logic [NFEAT-1:0][FW-1:0] feat_q;
  logic [AW-1:0]            cur;
  logic [AW-1:0]            step;
  node_t                    nd;
  logic [FW-1:0]            fsel;
  logic                     le;

  assign nd        = tbl[cur];
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Indices with no backing feature read as zero.
  always_comb begin
    fsel = '0;
    for (int i = 0; i < NFEAT && i < 8; i++)
      if (nd.fidx == i[2:0]) fsel = feat_q[i];
  end

  assign le = (fsel <= nd.thr);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NODES; i++)
        tbl[i] <= node_t'({1'b1, {(NW-1){1'b0}}});
    end else if (cfg_we && state == IDLE) begin
      tbl[cfg_addr] <= node_t'(cfg_wdata);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_class <= '0;
      out_err   <= 1'b0;
      step      <= '0;
      cur       <= '0;
      feat_q    <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          feat_q <= in_feat;
          cur    <= '0;
          step   <= '0;
          state  <= WALK;
        end
        WALK: begin
          if (nd.leaf) begin
            out_class <= nd.thr[CW-1:0];
            out_err   <= 1'b0;
            state     <= DONE;
          end else if (step == AW'(NODES-1)) begin
            // NODES evaluations without a leaf means the table has a cycle.
            out_class <= '0;
            out_err   <= 1'b1;
            state     <= DONE;
          end else begin
            cur  <= le ? nd.left : nd.right;
            step <= step + 1'b1;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dtree_seq_eval.sv
// Directed bench for dtree_seq_eval: driver pushes expected results, a
// negedge monitor pops and checks class, error flag, latency and hold.
module tb_dtree_seq_eval;
  localparam int NFEAT = 8, FW = 8, NODES = 16, CW = 2, AW = 4, NW = 20;

  logic                clk = 0, rst_n = 0, cfg_we = 0;
  logic [AW-1:0]       cfg_addr = '0;
  logic [NW-1:0]       cfg_wdata = '0;
  logic                in_valid = 0, in_ready;
  logic [NFEAT*FW-1:0] in_feat = '0;
  logic                out_valid, out_ready = 1;
  logic [CW-1:0]       out_class;
  logic                out_err;

  dtree_seq_eval #(.NFEAT(NFEAT), .FW(FW), .NODES(NODES), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .in_valid(in_valid), .in_ready(in_ready),
    .in_feat(in_feat), .out_valid(out_valid), .out_ready(out_ready),
    .out_class(out_class), .out_err(out_err));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [CW-1:0] cls;
    logic          err;
    int            k;
    int            acc;
  } exp_t;

  exp_t q[$];
  int   tests = 0, fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: first cycle of each result is checked against the scoreboard,
  // later cycles of the same result must hold their values.
  initial begin
    logic          seen = 0;
    logic [CW-1:0] hcls = '0;
    logic          herr = 0;
    exp_t          e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (!seen) begin
          if (q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_result: class %0d err %0d with nothing pending", out_class, out_err);
          end else begin
            e = q.pop_front();
            chk("class", out_class, e.cls);
            chk("err", out_err, e.err);
            chk("latency", cyc - e.acc, e.k);
          end
          seen = 1; hcls = out_class; herr = out_err;
        end else begin
          chk("hold_class", out_class, hcls);
          chk("hold_err", out_err, herr);
        end
      end
      if (!out_valid) seen = 0;
    end
  end

  function automatic logic [NW-1:0] mk(input logic l, input logic [2:0] fi,
      input logic [FW-1:0] th, input logic [AW-1:0] a, input logic [AW-1:0] b);
    return {l, fi, th, a, b};
  endfunction

  function automatic logic [NFEAT*FW-1:0] fv(input int idx, input logic [FW-1:0] v,
      input logic [FW-1:0] bg);
    logic [NFEAT*FW-1:0] f;
    f = {NFEAT{bg}};
    f[idx*FW +: FW] = v;
    return f;
  endfunction

  task automatic wr(input logic [AW-1:0] a, input logic [NW-1:0] d);
    @(negedge clk); cfg_we = 1; cfg_addr = a; cfg_wdata = d;
    @(negedge clk); cfg_we = 0;
  endtask

  task automatic start(input logic [NFEAT*FW-1:0] f, input logic [CW-1:0] c,
      input logic e, input int k, input logic we = 0, input logic [NW-1:0] wd = '0);
    int n = 0;
    @(negedge clk);
    in_valid = 1; in_feat = f; cfg_we = we; cfg_addr = '0; cfg_wdata = wd;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL accept_timeout: in_ready stuck low");
    end else q.push_back('{c, e, k, cyc + 1});
    @(negedge clk);
    in_valid = 0; cfg_we = 0; in_feat = {$urandom, $urandom};
  endtask

  task automatic wait_done();
    int n = 0;
    while ((q.size() != 0 || out_valid) && n < 100) begin @(negedge clk); n++; end
    if (q.size() != 0 || out_valid) begin
      tests++; fails++;
      $display("FAIL result_timeout: pending %0d out_valid %0d", q.size(), out_valid);
      q.delete();
    end
  endtask

  task automatic run(input logic [NFEAT*FW-1:0] f, input logic [CW-1:0] c,
      input logic e, input int k);
    start(f, c, e, k);
    wait_done();
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_class", out_class, 0);
    chk("rst_out_err", out_err, 0);

    // Default table is a single class-0 leaf.
    run('0, 0, 0, 1);

    // Two-level tree on feature 6, threshold boundary at 133.
    wr(0, mk(0, 6, 133, 1, 2));
    wr(1, mk(1, 0, 1, 0, 0));
    wr(2, mk(1, 0, 3, 0, 0));
    run(fv(6, 133, 0), 1, 0, 2);
    run(fv(6, 134, 0), 3, 0, 2);
    run(fv(6, 0, 255), 1, 0, 2);
    run(fv(6, 255, 0), 3, 0, 2);

    // Backpressure: result held, no new input, config write dropped.
    out_ready = 0;
    start(fv(6, 200, 0), 3, 0, 2);
    n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    chk("bp_valid_seen", out_valid, 1);
    wr(0, mk(1, 0, 1, 0, 0));
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
    end
    out_ready = 1;
    wait_done();
    @(negedge clk);
    chk("bp_release_in_ready", in_ready, 1);
    run(fv(6, 200, 0), 3, 0, 2);

    // Self loop on node 0 exhausts the step budget.
    wr(0, mk(0, 0, 0, 0, 0));
    run('0, 0, 1, NODES);

    // Reset mid-walk abandons the walk and restores the table.
    @(negedge clk); in_valid = 1; in_feat = '0;
    @(negedge clk); in_valid = 0;
    repeat (3) @(negedge clk);
    rst_n = 0;
    @(negedge clk); rst_n = 1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    repeat (20) @(negedge clk);
    run('0, 0, 0, 1);

    // Write and handshake in the same cycle: walk sees the new node.
    start('0, 2, 0, 1, 1, mk(1, 0, 2, 0, 0));
    wait_done();

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
